// File: rtl/fifo_write_serializer.sv
`timescale 1ns/1ps
// Write-side front end for the async FIFO: serializes wide framed words MSB byte
// first onto the FIFO write port and appends an XOR checksum byte per frame.
module fifo_write_serializer #(
  parameter int IN_WIDTH   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_write,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [1:0]            dbg_state_o
);

  localparam int R    = IN_WIDTH / DATA_WIDTH;
  localparam int IDXW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    CSUM  = 2'd3
  } state_e;

  state_e                state_q;
  logic [IN_WIDTH-1:0]   sh_q;
  logic [IDXW-1:0]       byte_idx_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] csum_q;
  logic [CNT_WIDTH-1:0]  frame_count_q;
  // Holds s_ready low until the first clock edge after reset is released.
  logic                  rdy_en_q;

  logic                  last_byte;
  logic                  accept;
  logic [DATA_WIDTH-1:0] top_byte;

  assign top_byte  = sh_q[IN_WIDTH-1 -: DATA_WIDTH];
  assign last_byte = (byte_idx_q == IDXW'(R - 1));
  assign accept    = s_valid && s_ready;

  always_comb begin
    s_ready = 1'b0;
    if (rdy_en_q) begin
      s_ready = (state_q == IDLE) || (state_q == WAIT) ||
                ((state_q == SHIFT) && last_byte && !last_q && !fifo_full);
    end
  end

  assign fifo_write  = ((state_q == SHIFT) || (state_q == CSUM)) && !fifo_full;
  assign fifo_data   = (state_q == CSUM) ? csum_q : top_byte;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;
  assign dbg_state_o = state_q;

  // Reset is active-high on rst_n; a frame in flight is simply dropped.
  always_ff @(posedge clk_write or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      byte_idx_q    <= '0;
      last_q        <= 1'b0;
      csum_q        <= '0;
      frame_count_q <= '0;
      rdy_en_q      <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        IDLE, WAIT: begin
          if (accept) begin
            sh_q       <= s_data;
            last_q     <= s_last;
            byte_idx_q <= '0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!fifo_full) begin
            csum_q     <= csum_q ^ top_byte;
            sh_q       <= sh_q << DATA_WIDTH;
            byte_idx_q <= byte_idx_q + 1'b1;
            if (last_byte) begin
              if (last_q) begin
                state_q <= CSUM;
              end else if (accept) begin
                // Next word of the frame follows with no bubble.
                sh_q       <= s_data;
                last_q     <= s_last;
                byte_idx_q <= '0;
              end else begin
                state_q <= WAIT;
              end
            end
          end
        end
        CSUM: begin
          if (!fifo_full) begin
            csum_q        <= '0;
            frame_count_q <= frame_count_q + 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_serializer.sv
`timescale 1ns/1ps
// Bench for fifo_write_serializer: directed test-plan scenarios with literal
// byte expectations plus randomized frames checked against a byte-queue model.
module tb_fifo_write_serializer;

  localparam int IN_W = 32;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int R    = IN_W / DW;

  // Clock / reset
  logic clk_write = 1'b0;
  logic rst_n     = 1'b1;
  always #5 clk_write = ~clk_write;

  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [IN_W-1:0] s_data  = '0;
  logic            s_last  = 1'b0;
  logic            fifo_full = 1'b0;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data;
  logic            busy;
  logic [CW-1:0]   frame_count;
  logic [1:0]      dbg_state;

  fifo_write_serializer #(.IN_WIDTH(IN_W), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_write  (clk_write),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .frame_count(frame_count),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected byte stream, bit DW flags the checksum byte.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_csum  = '0;
  int            m_cnt   = 0;
  bit            m_frame = 1'b0;
  int            cyc     = 0;
  logic [DW-1:0] log_q[$];
  int            wcyc_q[$];
  int            acc_cyc_q[$];

  always @(negedge clk_write) begin
    cyc++;
    if (rst_n) begin
      exp_q.delete();
      m_csum  = '0;
      m_cnt   = 0;
      m_frame = 1'b0;
    end else begin
      chk("busy_model", busy, m_frame);
      chk("count_model", frame_count, m_cnt % (1 << CW));
      if (fifo_write && fifo_full) chk("write_while_full", 1, 0);
      if (fifo_write) begin
        log_q.push_back(fifo_data);
        wcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", fifo_data, 32'hFFFF_FFFF);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("byte_model", fifo_data, e[DW-1:0]);
          if (e[DW]) begin
            m_cnt++;
            m_frame = 1'b0;
          end
        end
      end
      if (s_valid && s_ready) begin
        logic [IN_W-1:0] w;
        w = s_data;
        acc_cyc_q.push_back(cyc);
        m_frame = 1'b1;
        for (int i = R - 1; i >= 0; i--) begin
          logic [DW-1:0] b;
          b = w[i*DW +: DW];
          exp_q.push_back({1'b0, b});
          m_csum = m_csum ^ b;
        end
        if (s_last) begin
          exp_q.push_back({1'b1, m_csum});
          m_csum = '0;
        end
      end
    end
  end

  // Random backpressure source for the randomized phase.
  bit rand_full_en = 1'b0;
  always @(posedge clk_write) begin
    if (rand_full_en) begin
      #1 fifo_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Driver tasks
  task automatic send_word(input logic [IN_W-1:0] d, input logic l);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_write);
      if (s_ready) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk_write);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk_write);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk_write);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    wcyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic chk_log(input string name, input logic [DW-1:0] e[$], input bit contiguous);
    chk({name, "_len"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) chk({name, "_byte"}, log_q[i], e[i]);
    if (contiguous && wcyc_q.size() == e.size() && e.size() > 0)
      chk({name, "_span"}, wcyc_q[e.size()-1] - wcyc_q[0], e.size() - 1);
  endtask

  task automatic do_reset();
    @(posedge clk_write);
    #1 rst_n = 1'b1;
    @(negedge clk_write);
    chk("rst_ready", s_ready, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    @(posedge clk_write);
    #1 rst_n = 1'b0;
    @(negedge clk_write);
    chk("ready_held_after_rst", s_ready, 0);
    @(posedge clk_write);
    #1;
    @(negedge clk_write);
    chk("ready_rises", s_ready, 1);
    @(posedge clk_write);
    #1;
  endtask

  logic [DW-1:0] eb[$];

  initial begin
    repeat (3) @(posedge clk_write);
    do_reset();

    // Single-word frame
    clear_log();
    send_word(32'h11223344, 1'b1);
    wait_idle();
    eb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    chk_log("single", eb, 1'b1);
    chk("single_count", frame_count, 1);
    chk("single_busy", busy, 0);

    // Two-word frame, continuous valid
    clear_log();
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'h0000000F, 1'b1);
    wait_idle();
    eb = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F};
    chk_log("two_word", eb, 1'b1);
    if (acc_cyc_q.size() == 2 && wcyc_q.size() >= 4)
      chk("two_word_accept_cyc", acc_cyc_q[1], wcyc_q[3]);
    else
      chk("two_word_accepts", acc_cyc_q.size(), 2);
    chk("two_word_count", frame_count, 2);

    // Backpressure on the third byte
    clear_log();
    send_word(32'hDEADBEEF, 1'b1);
    @(posedge clk_write);
    #1;
    @(posedge clk_write);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_write);
      chk("stall_write", fifo_write, 0);
      chk("stall_data", fifo_data, 8'hBE);
      @(posedge clk_write);
      #1;
    end
    fifo_full = 1'b0;
    wait_idle();
    eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    chk_log("backpressure", eb, 1'b0);
    chk("bp_count", frame_count, 3);

    // Upstream gap mid-frame
    clear_log();
    send_word(32'h01020304, 1'b0);
    repeat (4) begin
      @(posedge clk_write);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_write);
      chk("gap_ready", s_ready, 1);
      chk("gap_busy", busy, 1);
      chk("gap_nowrite", fifo_write, 0);
      @(posedge clk_write);
      #1;
    end
    send_word(32'h05060708, 1'b1);
    wait_idle();
    eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    chk_log("gap", eb, 1'b0);
    chk("gap_count_wrap", frame_count, 0);

    // Reset mid-frame
    clear_log();
    send_word(32'hCAFEF00D, 1'b1);
    @(posedge clk_write);
    #1;
    @(posedge clk_write);
    #1 rst_n = 1'b1;
    @(negedge clk_write);
    chk("midrst_write", fifo_write, 0);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_count", frame_count, 0);
    @(posedge clk_write);
    #1 rst_n = 1'b0;
    @(negedge clk_write);
    chk("midrst_ready_held", s_ready, 0);
    @(posedge clk_write);
    #1;
    eb = '{8'hCA, 8'hFE};
    chk_log("aborted", eb, 1'b1);
    clear_log();
    send_word(32'h000000AA, 1'b1);
    wait_idle();
    eb = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA};
    chk_log("after_reset", eb, 1'b1);
    chk("after_reset_count", frame_count, 1);

    // Counter wrap with a 2-bit counter
    do_reset();
    for (int f = 0; f < 5; f++) begin
      int exp_cnt [5] = '{1, 2, 3, 0, 1};
      send_word($urandom, 1'b1);
      wait_idle();
      chk("wrap_count", frame_count, exp_cnt[f]);
    end

    // Randomized frames with random backpressure and gaps
    rand_full_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_write);
          #1;
        end
        send_word($urandom, (w == nw - 1));
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rand_full_en = 1'b0;
    @(posedge clk_write);
    #1 fifo_full = 1'b0;
    wait_idle();
    chk("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
